// File: rtl/fifo_pkg.sv
// Shared helpers and constants for the parametrised synchronous FIFO.
// Sizing functions, reset values of the status flags, extension-mode encodings.
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Occupancy needs one bit more than the address to represent "completely full".
  function automatic int lvl_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam logic RST_EMPTY  = 1'b1;
  localparam logic RST_FULL   = 1'b0;
  localparam logic RST_AEMPTY = 1'b1;
  localparam logic RST_AFULL  = 1'b0;

  localparam int EXT_ZERO = 0;
  localparam int EXT_SIGN = 1;

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Not reset, so it maps onto block RAM.
module fifo_sync_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable thresholds, exact level and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through; otherwise reads have 1-cycle latency.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int STORE_WIDTH = 16,
  parameter int SIGN_EXT    = EXT_ZERO,
  parameter int FIFO_DEPTH  = 8192,
  parameter int AF_LEVEL    = FIFO_DEPTH - 16,
  parameter int AE_LEVEL    = 16,
  localparam int AW = clog2(FIFO_DEPTH),
  localparam int LW = lvl_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [LW-1:0]         water_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

  logic [LW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n, level_q;
  logic          empty_q, full_q, af_q, ae_q, ovf_q, unf_q, full_n;
  logic          wr_acc, rd_acc;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_raddr;
  logic [STORE_WIDTH-1:0] wr_word, ram_q, out_word;

  assign wr_word = wr_data[STORE_WIDTH-1:0];

  fifo_sync_ram #(.WIDTH(STORE_WIDTH), .DEPTH(FIFO_DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_word),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

`ifdef FIFO_FWFT_EN
  // Head word lives in head_q; RAM holds the words behind it. The RAM read port
  // continuously tracks the next RAM head, with a bypass for same-cycle writes.
  logic                   ram_pop, ram_empty, head_vld, head_vld_n, head_ld, fwd_q;
  logic [STORE_WIDTH-1:0] head_q, head_src, ram_head, fwd_data_q;

  assign head_vld = ~empty_q;
  assign ram_head = fwd_q ? fwd_data_q : ram_q;

  always_comb begin
    wr_acc     = wr_en & ~full_q & ~flush;
    rd_acc     = rd_en & ~empty_q & ~flush;
    ram_empty  = (wr_ptr == rd_ptr);
    head_ld    = 1'b0;
    head_src   = wr_word;
    head_vld_n = head_vld;
    ram_we     = 1'b0;
    ram_pop    = 1'b0;
    if (!head_vld) begin
      if (wr_acc) begin
        head_ld    = 1'b1;
        head_vld_n = 1'b1;
      end
    end else if (rd_acc && ram_empty) begin
      if (wr_acc) head_ld = 1'b1;
      else        head_vld_n = 1'b0;
    end else begin
      ram_we = wr_acc;
      if (rd_acc) begin
        head_ld  = 1'b1;
        head_src = ram_head;
        ram_pop  = 1'b1;
      end
    end
    if (flush) head_vld_n = 1'b0;
    wr_ptr_n  = flush ? '0 : wr_ptr + LW'(ram_we);
    rd_ptr_n  = flush ? '0 : rd_ptr + LW'(ram_pop);
    level_n   = (wr_ptr_n - rd_ptr_n) + LW'(head_vld_n);
    full_n    = (level_n == DEPTH_L);
    ram_re    = 1'b1;
    ram_raddr = rd_ptr_n[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      if (head_ld) head_q <= head_src;
      fwd_q      <= ram_we & (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0]);
      fwd_data_q <= wr_word;
    end
  end

  assign out_word = head_q;
  assign rd_valid = ~empty_q;
`else
  // rd_data reads 0 until the first word is ever popped, then holds the RAM output.
  logic rd_vld_q, has_data_q;

  always_comb begin
    wr_acc    = wr_en & ~full_q & ~flush;
    rd_acc    = rd_en & ~empty_q & ~flush;
    wr_ptr_n  = flush ? '0 : wr_ptr + LW'(wr_acc);
    rd_ptr_n  = flush ? '0 : rd_ptr + LW'(rd_acc);
    level_n   = wr_ptr_n - rd_ptr_n;
    full_n    = (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) && (wr_ptr_n[AW] != rd_ptr_n[AW]);
    ram_we    = wr_acc;
    ram_re    = rd_acc;
    ram_raddr = rd_ptr[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      has_data_q <= 1'b0;
    end else begin
      rd_vld_q   <= rd_acc;
      has_data_q <= has_data_q | rd_acc;
    end
  end

  assign out_word = has_data_q ? ram_q : '0;
  assign rd_valid = rd_vld_q;
`endif

  // Status is computed from next-state pointers so all flags agree with the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      empty_q <= RST_EMPTY;
      full_q  <= RST_FULL;
      ae_q    <= RST_AEMPTY;
      af_q    <= RST_AFULL;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      level_q <= level_n;
      empty_q <= (level_n == '0);
      full_q  <= full_n;
      af_q    <= (level_n >= AF_L);
      ae_q    <= (level_n <= AE_L);
      ovf_q   <= ~flush & (ovf_q | (wr_en & full_q));
      unf_q   <= ~flush & (unf_q | (rd_en & empty_q));
    end
  end

  generate
    if (STORE_WIDTH == DATA_WIDTH) begin : g_noext
      assign rd_data = out_word;
    end else begin : g_ext
      logic ext_bit, unused_hi;
      assign ext_bit   = (SIGN_EXT == EXT_SIGN) ? out_word[STORE_WIDTH-1] : 1'b0;
      assign rd_data   = {{(DATA_WIDTH-STORE_WIDTH){ext_bit}}, out_word};
      assign unused_hi = ^wr_data[DATA_WIDTH-1:STORE_WIDTH];
    end
  endgenerate

  assign full         = full_q;
  assign almost_full  = af_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign water_level  = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (standard-latency build): depth 16, AF 12, AE 2,
// plus two 11-bit-storage instances for sign/zero extension.
module tb_fifo_sync_param;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full, almost_full, rd_valid, empty, almost_empty, overflow, underflow;
  logic [15:0] rd_data;
  logic [4:0]  water_level;

  logic        x_wr = 1'b0, x_rd = 1'b0;
  logic [15:0] x_data = '0;
  logic        sx_full, sx_af, sx_vld, sx_empty, sx_ae, sx_ovf, sx_unf;
  logic [15:0] sx_data;
  logic [4:0]  sx_lvl;
  logic        zx_full, zx_af, zx_vld, zx_empty, zx_ae, zx_ovf, zx_unf;
  logic [15:0] zx_data;
  logic [4:0]  zx_lvl;

  int n_tests = 0, n_fail = 0;
  logic [15:0] q[$];
  logic [15:0] exp_w;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(16), .STORE_WIDTH(16), .SIGN_EXT(0),
                    .FIFO_DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
    .water_level(water_level), .overflow(overflow), .underflow(underflow));

  fifo_sync_param #(.DATA_WIDTH(16), .STORE_WIDTH(11), .SIGN_EXT(1),
                    .FIFO_DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) u_sx (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(x_wr), .wr_data(x_data),
    .full(sx_full), .almost_full(sx_af), .rd_en(x_rd), .rd_data(sx_data),
    .rd_valid(sx_vld), .empty(sx_empty), .almost_empty(sx_ae),
    .water_level(sx_lvl), .overflow(sx_ovf), .underflow(sx_unf));

  fifo_sync_param #(.DATA_WIDTH(16), .STORE_WIDTH(11), .SIGN_EXT(0),
                    .FIFO_DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) u_zx (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(x_wr), .wr_data(x_data),
    .full(zx_full), .almost_full(zx_af), .rd_en(x_rd), .rd_data(zx_data),
    .rd_valid(zx_vld), .empty(zx_empty), .almost_empty(zx_ae),
    .water_level(zx_lvl), .overflow(zx_ovf), .underflow(zx_unf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_empty", empty, 1); chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);   chk("rst_af", almost_full, 0);
    chk("rst_lvl", water_level, 0); chk("rst_vld", rd_valid, 0);
    chk("rst_data", rd_data, 0); chk("rst_ovf", overflow, 0); chk("rst_unf", underflow, 0);
    rst_n = 1'b1;
    step();

    // fill 0x1..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 16'(i);
      step();
      chk($sformatf("fill_lvl%0d", i), water_level, i);
      chk($sformatf("fill_full%0d", i), full, (i == 16));
      chk($sformatf("fill_af%0d", i), almost_full, (i >= 12));
      chk($sformatf("fill_ae%0d", i), almost_empty, (i <= 2));
      chk($sformatf("fill_empty%0d", i), empty, 0);
    end

    // write while full is dropped
    wr_data = 16'hAAAA;
    step();
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1); chk("ovf_lvl", water_level, 16); chk("ovf_full", full, 1);

    // drain in order
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step();
      chk($sformatf("drain_vld%0d", i), rd_valid, 1);
      chk($sformatf("drain_data%0d", i), rd_data, i);
      chk($sformatf("drain_lvl%0d", i), water_level, 16 - i);
    end
    rd_en = 1'b0;
    step();
    chk("drain_vld_off", rd_valid, 0); chk("drain_empty", empty, 1);
    chk("drain_hold", rd_data, 16'h0010); chk("ovf_sticky", overflow, 1);
    chk("drain_unf", underflow, 0);

    // underflow then flush
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("unf_set", underflow, 1); chk("unf_vld", rd_valid, 0); chk("unf_lvl", water_level, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ovf", overflow, 0); chk("fl_unf", underflow, 0);
    chk("fl_lvl", water_level, 0); chk("fl_hold", rd_data, 16'h0010);

    // extension on 11-bit storage
    x_wr = 1'b1; x_data = 16'h0400; step();
    x_data = 16'hFBFF; step();
    x_data = 16'h07FF; step();
    x_wr = 1'b0; x_rd = 1'b1;
    step();
    chk("sx_0400", sx_data, 16'hFC00); chk("zx_0400", zx_data, 16'h0400); chk("sx_vld", sx_vld, 1);
    step();
    chk("sx_fbff", sx_data, 16'h03FF); chk("zx_fbff", zx_data, 16'h03FF);
    step();
    x_rd = 1'b0;
    chk("sx_07ff", sx_data, 16'hFFFF); chk("zx_07ff", zx_data, 16'h07FF); chk("zx_empty", zx_empty, 1);

    // level 8, simultaneous traffic across pointer wrap
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 16'h0100 + 16'(i); q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    chk("l8_lvl", water_level, 8); chk("l8_ae", almost_empty, 0); chk("l8_af", almost_full, 0);
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h0200 + 16'(k); q.push_back(wr_data);
      step();
      exp_w = q.pop_front();
      chk($sformatf("wrap_data%0d", k), rd_data, exp_w);
      chk($sformatf("wrap_vld%0d", k), rd_valid, 1);
      chk($sformatf("wrap_lvl%0d", k), water_level, 8);
    end
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hDEAD;
    step();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    q.delete();
    chk("wfl_lvl", water_level, 0); chk("wfl_empty", empty, 1); chk("wfl_vld", rd_valid, 0);
    chk("wfl_hold", rd_data, exp_w); chk("wfl_unf", underflow, 0);
    step();
    chk("wfl_discard", water_level, 0); chk("wfl_full", full, 0);

    // async reset mid-burst at level 5
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 16'h0050 + 16'(i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("mid_lvl", water_level, 5); chk("mid_data", rd_data, 16'h0050);
    wr_en = 1'b1; wr_data = 16'h0099;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lvl", water_level, 0); chk("arst_empty", empty, 1); chk("arst_ae", almost_empty, 1);
    chk("arst_full", full, 0); chk("arst_af", almost_full, 0); chk("arst_data", rd_data, 0);
    chk("arst_vld", rd_valid, 0); chk("arst_ovf", overflow, 0); chk("arst_unf", underflow, 0);
    wr_en = 1'b0;
    #2 rst_n = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 16'h0077;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("post_data", rd_data, 16'h0077); chk("post_vld", rd_valid, 1);
    chk("post_lvl", water_level, 0); chk("post_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
